lsu_apb_bridge: RTL and testbench
=================================

LSU_APB_BRIDGE -- requirements
Module: lsu_apb_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of ACCESS cycles allowed without PREADY before the transfer is aborted.
REQ-002 SHALL have ports:
- clk  in  1  clock.
- reset  in  1  reset. One clock; reset is synchronous and active-high.
- req_valid  in  1  load/store request from the core.
- req_write  in  1  1 = store, 0 = load.
- req_func3  in  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address (core ALU result).
- req_wdata  in  32  store data (core rs2).
- req_ready  out  1  one-cycle completion pulse.
- rdata  out  32  extended load data.
- err  out  1  misaligned, illegal func3, PSLVERR or timeout.
- PADDR  out  32  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB write.
- PWDATA  out  32  APB write data.
- PSTRB  out  4  APB byte strobes.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.
REQ-003 SHALL make every output a registered signal.

Function
REQ-004 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-005 SHALL register req_* in IDLE when req_valid=1, and ignore req_* in all other states; the core holds req_valid until it sees req_ready.
REQ-006 SHALL define lane = req_addr[1:0] and classify a request as illegal when any of these hold:
- func3 is 011, 110 or 111;
- func3 is 001 or 101 and lane[0]=1;
- func3 is 010 and lane != 0.
REQ-007 SHALL go IDLE -> RESP for an illegal request, raising no APB signals.
REQ-008 SHALL go IDLE -> SETUP for a legal request.
REQ-009 SHALL drive the following in SETUP:
- PSEL=1, PENABLE=0;
- PADDR = {addr[31:2],2'b00};
- PWRITE = req_write;
- PWDATA and PSTRB per REQ-012.
Then SETUP -> ACCESS unconditionally.
REQ-010 SHALL hold PSEL=1, PENABLE=1 in ACCESS, with PADDR, PWRITE, PWDATA and PSTRB stable; ACCESS -> RESP on PREADY=1.
REQ-011 SHALL count ACCESS cycles and, when the count reaches TIMEOUT_CYCLES with PREADY=0, go ACCESS -> RESP with err=1.
REQ-012 SHALL form store data and strobes as follows:
- Byte: PWDATA = {4{wdata[7:0]}}, PSTRB = 4'b0001<<lane.
- Half: PWDATA = {2{wdata[15:0]}}, PSTRB = 4'b0011<<lane.
- Word: PWDATA = wdata, PSTRB = 4'b1111.
- Loads: PSTRB = 0.
REQ-013 SHALL, on the ACCESS cycle with PREADY=1 for a load, capture the PRDATA lane(s) selected by lane:
- sign-extend for func3 000/001;
- zero-extend for func3 100/101;
- pass through unchanged for 010.
REQ-014 SHALL in RESP drive:
- req_ready=1 for exactly one cycle, with PSEL=0 and PENABLE=0;
- err=1 if the request was illegal, PSLVERR=1 at completion, or a timeout occurred, else err=0;
- rdata = 0 for stores or on err=1.
Then RESP -> IDLE.
REQ-015 SHALL hold rdata and err stable until the next RESP; req_ready is 0 outside RESP.
REQ-016 SHALL give latency for a legal request accepted in cycle N with PREADY=1 immediately: SETUP N+1, ACCESS N+2, req_ready N+3; each PREADY wait cycle adds 1.
REQ-017 SHALL accept a new request no earlier than the cycle after RESP; back-to-back throughput is one transfer per 4 cycles at best.
REQ-018 SHALL ignore PREADY, PSLVERR and PRDATA outside ACCESS.

Reset
REQ-019 SHALL, on a clk edge with reset=1 in any state (including mid-ACCESS), enter IDLE and clear all outputs, the captured request and the timeout counter to 0.
REQ-020 SHALL not complete an aborted transfer: no req_ready pulse is issued for it.

Verification
REQ-021 SHALL cover: LB, addr=0x103, PRDATA=0x80FF_FF00, PREADY=1 -> PADDR=0x100, PSTRB=0, rdata=0xFFFF_FF80, err=0, req_ready in cycle N+3.
REQ-022 SHALL cover: SH, addr=0x202, wdata=0x1234_ABCD -> PWDATA=0xABCD_ABCD, PSTRB=4'b1100, PWRITE=1, rdata=0.
REQ-023 SHALL cover: LW, addr=0x006 -> no PSEL ever, req_ready at N+1, err=1.
REQ-024 SHALL cover: LHU, addr=0x10, PREADY low 3 cycles then high, PRDATA=0x0000_F00D -> rdata=0x0000_F00D, req_ready at N+6.
REQ-025 SHALL cover: SW with PREADY stuck 0, TIMEOUT_CYCLES=16 -> PSEL drops after 16 ACCESS cycles, req_ready with err=1.
REQ-026 SHALL cover: reset asserted during ACCESS -> next edge PSEL=0, PENABLE=0, req_ready=0, FSM IDLE; a new request then completes normally.

Source files
------------

// File: rtl/lsu_apb_bridge.sv
// Load/store unit to APB requester bridge: one outstanding RV32I access,
// lane steering of store data/strobes, load extension, and an ACCESS-phase timeout.
module lsu_apb_bridge #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] PADDR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    output logic [3:0]  PSTRB,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t           state;
    logic [2:0]       func3_q;
    logic [1:0]       lane_q;
    logic             write_q;
    logic [CNT_W-1:0] tmo_cnt;

    function automatic logic is_illegal(input logic [2:0] f3, input logic [1:0] lane);
        case (f3)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return lane[0];
            3'b010:         return lane != 2'b00;
            default:        return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'b00:   return 4'b0001 << lane;
            2'b01:   return 4'b0011 << lane;
            default: return 4'b1111;
        endcase
    endfunction

    // Selects the addressed byte/half from the bus word and extends it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                                input logic [31:0] d);
        logic [31:0]        shifted;
        logic [7:0]         b;
        logic [15:0]        h;
        logic signed [7:0]  bs;
        logic signed [15:0] hs;
        logic signed [31:0] r;
        shifted = d >> {lane, 3'b000};
        b       = shifted[7:0];
        h       = lane[1] ? d[31:16] : d[15:0];
        bs      = b;
        hs      = h;
        case (f3)
            3'b000:  r = bs;
            3'b001:  r = hs;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = d;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            func3_q   <= 3'd0;
            lane_q    <= 2'd0;
            write_q   <= 1'b0;
            tmo_cnt   <= '0;
            req_ready <= 1'b0;
            rdata     <= 32'd0;
            err       <= 1'b0;
            PADDR     <= 32'd0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PWDATA    <= 32'd0;
            PSTRB     <= 4'd0;
        end else begin
            req_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        func3_q <= req_func3;
                        lane_q  <= req_addr[1:0];
                        write_q <= req_write;
                        tmo_cnt <= '0;
                        if (is_illegal(req_func3, req_addr[1:0])) begin
                            // Rejected without touching the bus.
                            state     <= RESP;
                            req_ready <= 1'b1;
                            err       <= 1'b1;
                            rdata     <= 32'd0;
                        end else begin
                            state   <= SETUP;
                            PSEL    <= 1'b1;
                            PENABLE <= 1'b0;
                            PADDR   <= {req_addr[31:2], 2'b00};
                            PWRITE  <= req_write;
                            PWDATA  <= req_write ? store_data(req_func3, req_wdata) : 32'd0;
                            PSTRB   <= req_write ? store_strb(req_func3, req_addr[1:0]) : 4'd0;
                        end
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                end
                ACCESS: begin
                    if (PREADY) begin
                        state     <= RESP;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        req_ready <= 1'b1;
                        err       <= PSLVERR;
                        rdata     <= (!write_q && !PSLVERR) ?
                                     load_extend(func3_q, lane_q, PRDATA) : 32'd0;
                    end else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state     <= RESP;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        req_ready <= 1'b1;
                        err       <= 1'b1;
                        rdata     <= 32'd0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_apb_bridge.sv
// Directed bench for lsu_apb_bridge: stimulus pushes expected responses,
// a monitor pops and compares them whenever req_ready pulses.
module tb_lsu_apb_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_func3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA = 32'hDEAD_BEEF;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;

    lsu_apb_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_func3(req_func3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rdata(rdata), .err(err),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        int          tag;
    } exp_t;
    exp_t sb[$];

    // Monitor
    initial forever begin
        @(negedge clk);
        if (req_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_req_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("resp tag=%0d cyc=%0d rdata=%h err=%0d", e.tag, cyc, rdata, err);
                check("rdata", rdata, e.rdata);
                check("err", {31'd0, err}, {31'd0, e.err});
                check("latency", cyc, e.cyc);
            end
        end
    end

    // APB slave: PREADY after sl_wait ACCESS cycles, or never when sl_stuck.
    int          sl_wait = 0;
    logic        sl_stuck = 1'b0;
    logic        sl_err = 1'b0;
    logic [31:0] sl_prdata = 32'd0;
    initial begin
        int acc;
        acc = 0;
        forever begin
            @(negedge clk);
            if (PSEL && PENABLE) begin
                PREADY  = !sl_stuck && (acc >= sl_wait);
                PSLVERR = PREADY && sl_err;
                PRDATA  = PREADY ? sl_prdata : 32'hDEAD_BEEF;
                acc++;
            end else begin
                PREADY  = 1'b0;
                PSLVERR = 1'b0;
                PRDATA  = 32'hDEAD_BEEF;
                acc     = 0;
            end
        end
    end

    int tag_n = 0;

    task automatic run_req(input string nm, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] prd, input int waits, input logic stuck,
                           input logic slverr, input logic exp_apb,
                           input logic [31:0] exp_paddr, input logic [31:0] exp_pwdata,
                           input logic [3:0] exp_pstrb, input logic [31:0] exp_rdata,
                           input logic exp_err, input int exp_lat);
        int   n;
        int   acc_seen;
        logic saw_psel;
        logic saw_setup;
        logic done;
        exp_t e;
        @(negedge clk);
        sl_wait   = waits;
        sl_stuck  = stuck;
        sl_err    = slverr;
        sl_prdata = prd;
        req_valid = 1'b1;
        req_write = wr;
        req_func3 = f3;
        req_addr  = addr;
        req_wdata = wd;
        n = cyc;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.cyc   = n + exp_lat;
        e.tag   = tag_n++;
        sb.push_back(e);
        acc_seen  = 0;
        saw_psel  = 1'b0;
        saw_setup = 1'b0;
        done      = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (PSEL) saw_psel = 1'b1;
            if (PSEL && PENABLE) acc_seen++;
            if (PSEL && !PENABLE && !saw_setup) begin
                saw_setup = 1'b1;
                check({nm, "_setup_cyc"}, cyc, n + 1);
                check({nm, "_paddr"}, PADDR, exp_paddr);
                check({nm, "_pwrite"}, {31'd0, PWRITE}, {31'd0, wr});
                check({nm, "_pstrb"}, {28'd0, PSTRB}, {28'd0, exp_pstrb});
                if (wr) check({nm, "_pwdata"}, PWDATA, exp_pwdata);
            end
            if (req_ready) begin
                done = 1'b1;
                break;
            end
        end
        req_valid = 1'b0;
        check({nm, "_completed"}, {31'd0, done}, 32'd1);
        check({nm, "_psel_seen"}, {31'd0, saw_psel}, {31'd0, exp_apb});
        if (exp_apb) check({nm, "_access_cycles"}, acc_seen, stuck ? 16 : waits + 1);
        repeat (2) @(negedge clk);
        check({nm, "_ready_low"}, {31'd0, req_ready}, 32'd0);
        check({nm, "_rdata_hold"}, rdata, exp_rdata);
        check({nm, "_err_hold"}, {31'd0, err}, {31'd0, exp_err});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_psel", {31'd0, PSEL}, 32'd0);
        check("rst_penable", {31'd0, PENABLE}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_paddr", PADDR, 32'd0);
        check("rst_pstrb", {28'd0, PSTRB}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        //       name    wr  f3      addr          wdata         prdata        wt stk sle apb paddr         pwdata        pstrb    rdata         err lat
        run_req("lb",   0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_FF00, 0, 0, 0, 1, 32'h0000_0100, 32'h0,        4'b0000, 32'hFFFF_FF80, 0, 3);
        run_req("sh",   1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0,        0, 0, 0, 1, 32'h0000_0200, 32'hABCD_ABCD, 4'b1100, 32'h0,        0, 3);
        run_req("lw_mis",0,3'b010, 32'h0000_0006, 32'h0,        32'h0,         0, 0, 0, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        1, 1);
        run_req("lhu",  0, 3'b101, 32'h0000_0010, 32'h0,        32'h0000_F00D, 3, 0, 0, 1, 32'h0000_0010, 32'h0,        4'b0000, 32'h0000_F00D, 0, 6);
        run_req("sw_to",1, 3'b010, 32'h0000_0300, 32'hCAFE_0001, 32'h0,        0, 1, 0, 1, 32'h0000_0300, 32'hCAFE_0001, 4'b1111, 32'h0,        1, 18);
        run_req("lh",   0, 3'b001, 32'h0000_0002, 32'h0,        32'h8001_1234, 0, 0, 0, 1, 32'h0000_0000, 32'h0,        4'b0000, 32'hFFFF_8001, 0, 3);
        run_req("sb",   1, 3'b000, 32'h0000_0401, 32'h0000_00AB, 32'h0,        1, 0, 0, 1, 32'h0000_0400, 32'hABAB_ABAB, 4'b0010, 32'h0,        0, 4);
        run_req("lw_se",0, 3'b010, 32'h0000_0010, 32'h0,        32'h1122_3344, 0, 0, 1, 1, 32'h0000_0010, 32'h0,        4'b0000, 32'h0,        1, 3);
        run_req("f3bad",0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,         0, 0, 0, 0, 32'h0,        32'h0,        4'b0000, 32'h0,        1, 1);
        run_req("lb_p", 0, 3'b000, 32'h0000_0000, 32'h0,        32'h0000_007F, 0, 0, 0, 1, 32'h0000_0000, 32'h0,        4'b0000, 32'h0000_007F, 0, 3);
        run_req("lw",   0, 3'b010, 32'h0000_0008, 32'h0,        32'hCAFE_F00D, 1, 0, 0, 1, 32'h0000_0008, 32'h0,        4'b0000, 32'hCAFE_F00D, 0, 4);

        // Reset in the middle of an ACCESS phase: no completion may follow.
        @(negedge clk);
        sl_stuck  = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_func3 = 3'b010;
        req_addr  = 32'h0000_0020;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (PSEL && PENABLE) begin
                ok = 1'b1;
                break;
            end
        end
        check("rst_mid_reached_access", {31'd0, ok}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_psel", {31'd0, PSEL}, 32'd0);
        check("rst_mid_penable", {31'd0, PENABLE}, 32'd0);
        check("rst_mid_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_mid_paddr", PADDR, 32'd0);
        reset     = 1'b0;
        req_valid = 1'b0;
        sl_stuck  = 1'b0;
        repeat (2) @(negedge clk);

        run_req("lbu",  0, 3'b100, 32'h0000_0041, 32'h0,        32'hA5C3_7E19, 0, 0, 0, 1, 32'h0000_0040, 32'h0,        4'b0000, 32'h0000_007E, 0, 3);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
